// File: rtl/draw_celownik.sv
// ---------------------------------------------------------------------------
// draw_celownik
//
// Crosshair overlay stage of the VGA pixel pipeline. It sits directly
// upstream of the 64x64 crosshair sprite ROM. It produces the sprite ROM
// address from the pixel counters and the latched crosshair position. One
// clock later it takes the ROM pixel and merges it over the background pixel.
// Sprite pixels equal to KEY_RGB are treated as transparent. The VGA timing
// bus is delayed by the same 3 clocks, so every output stays pixel-aligned.
//
// Optional feature (compile-time macro): CELOWNIK_BLINK_EN
//   When it is defined, a frame counter blinks the crosshair. The crosshair is
//   shown for BLINK_FRAMES frames, then hidden for BLINK_FRAMES frames.
//   When it is undefined, the crosshair is always visible.
//
// Ports:
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   hcount_in   horizontal pixel counter (11 bit)
//   vcount_in   vertical line counter (11 bit)
//   hsync_in    horizontal sync
//   hblnk_in    horizontal blank
//   vsync_in    vertical sync
//   vblnk_in    vertical blank
//   rgb_in      background pixel (12 bit)
//   xpos, ypos  crosshair centre, unsigned 12 bit
//   rom_rgb     sprite ROM pixel, valid 1 clk after rom_addr
//   rom_addr    sprite ROM address {addry[5:0], addrx[5:0]}
//   *_out       timing bus and counters delayed by 3 clk
//   rgb_out     merged pixel, 3 clk after rgb_in
// ---------------------------------------------------------------------------
module draw_celownik #(
  parameter int          SPRITE_W     = 64,
  parameter int          SPRITE_H     = 64,
`ifdef CELOWNIK_BLINK_EN
  parameter int          BLINK_FRAMES = 16,
`endif
  parameter logic [11:0] KEY_RGB      = 12'h0F0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [11:0] rom_rgb,
  output logic [11:0] rom_addr,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic signed [12:0] HALF_W = 13'(SPRITE_W / 2);
  localparam logic signed [12:0] HALF_H = 13'(SPRITE_H / 2);
  localparam logic signed [12:0] W13    = 13'(SPRITE_W);
  localparam logic signed [12:0] H13    = 13'(SPRITE_H);

  logic        vblnk_prev;
  logic        vblnk_rise;
  logic [11:0] x_lat;
  logic [11:0] y_lat;
  logic        blink_hide;

  logic signed [12:0] ox, oy, dx, dy;
  logic               in_box_c;

  logic [10:0] hcount_d1, vcount_d1, hcount_d2, vcount_d2;
  logic        hsync_d1, hblnk_d1, vsync_d1, vblnk_d1;
  logic        hsync_d2, hblnk_d2, vsync_d2, vblnk_d2;
  logic [11:0] rgb_d1, rgb_d2;
  logic        in_box_d1, in_box_d2;

  assign vblnk_rise = vblnk_in && !vblnk_prev;

  // The position is sampled only at the start of vertical blank, so the
  // crosshair never tears or jumps in the middle of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev <= 1'b0;
      x_lat      <= '0;
      y_lat      <= '0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_rise) begin
        x_lat <= xpos;
        y_lat <= ypos;
      end
    end
  end

`ifdef CELOWNIK_BLINK_EN
  localparam int FCW = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;

  logic [FCW-1:0] frame_cnt;

  // Counts frames modulo 2*BLINK_FRAMES. The upper half of the count hides
  // the crosshair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (vblnk_rise) begin
      if (frame_cnt == FCW'(2 * BLINK_FRAMES - 1)) frame_cnt <= '0;
      else                                         frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign blink_hide = (frame_cnt >= FCW'(BLINK_FRAMES));
`else
  assign blink_hide = 1'b0;
`endif

  // The sprite origin may be negative, which clips at the left/top edge. The
  // 13-bit signed arithmetic keeps large hcount values, such as 2047, from
  // aliasing into the box.
  always_comb begin
    ox       = $signed({1'b0, x_lat}) - HALF_W;
    oy       = $signed({1'b0, y_lat}) - HALF_H;
    dx       = $signed({2'b00, hcount_in}) - ox;
    dy       = $signed({2'b00, vcount_in}) - oy;
    in_box_c = (dx >= 13'sd0) && (dx < W13) &&
               (dy >= 13'sd0) && (dy < H13) &&
               !hblnk_in && !vblnk_in && !blink_hide;
  end

  // Stage 1: this stage issues the ROM address. Outside the box the address
  // is parked at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
      hcount_d1 <= '0;
      vcount_d1 <= '0;
      hsync_d1  <= 1'b0;
      hblnk_d1  <= 1'b0;
      vsync_d1  <= 1'b0;
      vblnk_d1  <= 1'b0;
      rgb_d1    <= '0;
    end else begin
      rom_addr  <= in_box_c ? {dy[5:0], dx[5:0]} : 12'h000;
      in_box_d1 <= in_box_c;
      hcount_d1 <= hcount_in;
      vcount_d1 <= vcount_in;
      hsync_d1  <= hsync_in;
      hblnk_d1  <= hblnk_in;
      vsync_d1  <= vsync_in;
      vblnk_d1  <= vblnk_in;
      rgb_d1    <= rgb_in;
    end
  end

  // Stage 2: the ROM registers the address during this stage. This stage
  // only carries the side information along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_box_d2 <= 1'b0;
      hcount_d2 <= '0;
      vcount_d2 <= '0;
      hsync_d2  <= 1'b0;
      hblnk_d2  <= 1'b0;
      vsync_d2  <= 1'b0;
      vblnk_d2  <= 1'b0;
      rgb_d2    <= '0;
    end else begin
      in_box_d2 <= in_box_d1;
      hcount_d2 <= hcount_d1;
      vcount_d2 <= vcount_d1;
      hsync_d2  <= hsync_d1;
      hblnk_d2  <= hblnk_d1;
      vsync_d2  <= vsync_d1;
      vblnk_d2  <= vblnk_d1;
      rgb_d2    <= rgb_d1;
    end
  end

  // Stage 3: this stage merges the pixel. A sprite pixel equal to the colour
  // key lets the background show through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_d2;
      vcount_out <= vcount_d2;
      hsync_out  <= hsync_d2;
      hblnk_out  <= hblnk_d2;
      vsync_out  <= vsync_d2;
      vblnk_out  <= vblnk_d2;
      rgb_out    <= (in_box_d2 && (rom_rgb != KEY_RGB)) ? rom_rgb : rgb_d2;
    end
  end

endmodule

// File: tb/tb_draw_celownik.sv
// ---------------------------------------------------------------------------
// tb_draw_celownik
//
// Directed self-checking bench for draw_celownik in its default build (no
// blink). A registered sprite ROM model feeds rom_rgb from rom_addr. The ROM
// returns the colour key at 0x080, red (0xF00) at 0xFFF, and addr^0x5A5
// everywhere else.
// ---------------------------------------------------------------------------
module tb_draw_celownik;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos, rom_rgb, rom_addr;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  draw_celownik dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .rom_rgb    (rom_rgb),
    .rom_addr   (rom_addr),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  function automatic logic [11:0] rom_data(input logic [11:0] a);
    if (a == 12'h080) return 12'h0F0;
    if (a == 12'hFFF) return 12'hF00;
    return a ^ 12'h5A5;
  endfunction

  // Registered sprite ROM model: one clock from address to data.
  always @(posedge clk) rom_rgb <= rom_data(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [10:0] h, input logic [10:0] v,
                                input logic [11:0] rgb);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = rgb;
  endtask

  // Produces a vblnk rising edge. The new position is presented in the same
  // cycle as the rising edge.
  task automatic latch_pos(input logic [11:0] x, input logic [11:0] y);
    xpos     = x;
    ypos     = y;
    vblnk_in = 1'b1;
    tick();
    vblnk_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_stimulus(11'd500, 11'd300, 12'hABC);
    hsync_in = 1'b1;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rgb_out !== 12'h000) begin
      n_fail++; $display("[TB] FAIL reset_rgb: got %h expected 000", rgb_out);
    end
    n_checks++;
    if (hsync_out !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_hsync: got %b expected 0", hsync_out);
    end
    n_checks++;
    if (hcount_out !== 11'd0 || vcount_out !== 11'd0) begin
      n_fail++; $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", hcount_out, vcount_out);
    end
    tick();
    n_checks++;
    if (rgb_out !== 12'h000 || rom_addr !== 12'h000) begin
      n_fail++; $display("[TB] FAIL reset_held: got rgb %h addr %h expected 000/000", rgb_out, rom_addr);
    end
    #2 rst_n = 1'b1;
    tick();
    n_checks++;
    if (rgb_out !== 12'h000) begin
      n_fail++; $display("[TB] FAIL release_clk1: got %h expected 000", rgb_out);
    end
    tick();
    n_checks++;
    if (rgb_out !== 12'h000) begin
      n_fail++; $display("[TB] FAIL release_clk2: got %h expected 000", rgb_out);
    end
    tick();
    n_checks++;
    if (rgb_out !== 12'hABC || hsync_out !== 1'b1 || hcount_out !== 11'd500) begin
      n_fail++; $display("[TB] FAIL release_clk3: got %h/%b/%0d expected ABC/1/500", rgb_out, hsync_out, hcount_out);
    end
  endtask

  task automatic test_latency();
    apply_stimulus(11'd501, 11'd301, 12'h123);
    hsync_in = 1'b0; hblnk_in = 1'b1; vsync_in = 1'b1; vblnk_in = 1'b1;
    tick();
    hblnk_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
    apply_stimulus(11'd502, 11'd301, 12'h456);
    hsync_in = 1'b1;
    n_checks++;
    if (rgb_out !== 12'hABC || hsync_out !== 1'b1) begin
      n_fail++; $display("[TB] FAIL latency_clk1: got %h/%b expected ABC/1", rgb_out, hsync_out);
    end
    tick();
    n_checks++;
    if (rgb_out !== 12'hABC || hsync_out !== 1'b1) begin
      n_fail++; $display("[TB] FAIL latency_clk2: got %h/%b expected ABC/1", rgb_out, hsync_out);
    end
    tick();
    n_checks++;
    if (rgb_out !== 12'h123 || hsync_out !== 1'b0 || hcount_out !== 11'd501 || vcount_out !== 11'd301) begin
      n_fail++; $display("[TB] FAIL latency_clk3: got %h/%b/%0d/%0d expected 123/0/501/301",
                         rgb_out, hsync_out, hcount_out, vcount_out);
    end
    n_checks++;
    if (hblnk_out !== 1'b1 || vsync_out !== 1'b1 || vblnk_out !== 1'b1) begin
      n_fail++; $display("[TB] FAIL latency_blanks: got %b%b%b expected 111", hblnk_out, vsync_out, vblnk_out);
    end
    tick();
    n_checks++;
    if (rgb_out !== 12'h456 || hblnk_out !== 1'b0 || hcount_out !== 11'd502) begin
      n_fail++; $display("[TB] FAIL latency_next: got %h/%b/%0d expected 456/0/502", rgb_out, hblnk_out, hcount_out);
    end
    hsync_in = 1'b0;
  endtask

  task automatic test_addressing();
    latch_pos(12'd100, 12'd100);
    apply_stimulus(11'd68, 11'd70, 12'h321);
    tick();
    n_checks++;
    if (rom_addr !== 12'h080) begin
      n_fail++; $display("[TB] FAIL addr_68_70: got %h expected 080", rom_addr);
    end
    repeat (2) tick();
    n_checks++;
    if (rgb_out !== 12'h321) begin
      n_fail++; $display("[TB] FAIL key_transparent: got %h expected 321", rgb_out);
    end
    apply_stimulus(11'd131, 11'd131, 12'h321);
    tick();
    n_checks++;
    if (rom_addr !== 12'hFFF) begin
      n_fail++; $display("[TB] FAIL addr_131_131: got %h expected FFF", rom_addr);
    end
    repeat (2) tick();
    n_checks++;
    if (rgb_out !== 12'hF00) begin
      n_fail++; $display("[TB] FAIL sprite_red: got %h expected F00", rgb_out);
    end
    apply_stimulus(11'd132, 11'd131, 12'h456);
    tick();
    n_checks++;
    if (rom_addr !== 12'h000) begin
      n_fail++; $display("[TB] FAIL addr_132_out: got %h expected 000", rom_addr);
    end
    repeat (2) tick();
    n_checks++;
    if (rgb_out !== 12'h456) begin
      n_fail++; $display("[TB] FAIL right_outside: got %h expected 456", rgb_out);
    end
    apply_stimulus(11'd100, 11'd100, 12'h789);
    tick();
    n_checks++;
    if (rom_addr !== 12'h820) begin
      n_fail++; $display("[TB] FAIL addr_centre: got %h expected 820", rom_addr);
    end
    repeat (2) tick();
    n_checks++;
    if (rgb_out !== 12'hD85) begin
      n_fail++; $display("[TB] FAIL sprite_centre: got %h expected D85", rgb_out);
    end
    hblnk_in = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (rgb_out !== 12'h789 || rom_addr !== 12'h000) begin
      n_fail++; $display("[TB] FAIL hblank_suppress: got %h/%h expected 789/000", rgb_out, rom_addr);
    end
    hblnk_in = 1'b0;
    apply_stimulus(11'd68, 11'd68, 12'h111);
    repeat (3) tick();
    n_checks++;
    if (rgb_out !== 12'h5A5 || rom_addr !== 12'h000) begin
      n_fail++; $display("[TB] FAIL corner_origin: got %h/%h expected 5A5/000", rgb_out, rom_addr);
    end
    apply_stimulus(11'd100, 11'd67, 12'h222);
    repeat (3) tick();
    n_checks++;
    if (rgb_out !== 12'h222) begin
      n_fail++; $display("[TB] FAIL top_outside: got %h expected 222", rgb_out);
    end
  endtask

  task automatic test_frame_latch();
    xpos = 12'd300;
    apply_stimulus(11'd68, 11'd70, 12'h111);
    tick();
    n_checks++;
    if (rom_addr !== 12'h080) begin
      n_fail++; $display("[TB] FAIL latch_hold_old: got %h expected 080", rom_addr);
    end
    apply_stimulus(11'd268, 11'd70, 12'h111);
    repeat (3) tick();
    n_checks++;
    if (rom_addr !== 12'h000 || rgb_out !== 12'h111) begin
      n_fail++; $display("[TB] FAIL latch_no_move: got %h/%h expected 000/111", rom_addr, rgb_out);
    end
    latch_pos(12'd300, 12'd100);
    apply_stimulus(11'd268, 11'd70, 12'h111);
    tick();
    n_checks++;
    if (rom_addr !== 12'h080) begin
      n_fail++; $display("[TB] FAIL latch_new_left: got %h expected 080", rom_addr);
    end
    apply_stimulus(11'd331, 11'd70, 12'h111);
    tick();
    n_checks++;
    if (rom_addr !== 12'h0BF) begin
      n_fail++; $display("[TB] FAIL latch_new_right: got %h expected 0BF", rom_addr);
    end
    apply_stimulus(11'd68, 11'd70, 12'h111);
    tick();
    n_checks++;
    if (rom_addr !== 12'h000) begin
      n_fail++; $display("[TB] FAIL latch_old_gone: got %h expected 000", rom_addr);
    end
  endtask

  task automatic test_left_clip();
    latch_pos(12'd10, 12'd100);
    apply_stimulus(11'd0, 11'd70, 12'h222);
    tick();
    n_checks++;
    if (rom_addr !== 12'h096) begin
      n_fail++; $display("[TB] FAIL clip_h0: got %h expected 096", rom_addr);
    end
    repeat (2) tick();
    n_checks++;
    if (rgb_out !== 12'h533) begin
      n_fail++; $display("[TB] FAIL clip_h0_rgb: got %h expected 533", rgb_out);
    end
    apply_stimulus(11'd41, 11'd70, 12'h222);
    tick();
    n_checks++;
    if (rom_addr !== 12'h0BF) begin
      n_fail++; $display("[TB] FAIL clip_h41: got %h expected 0BF", rom_addr);
    end
    apply_stimulus(11'd42, 11'd70, 12'h222);
    tick();
    n_checks++;
    if (rom_addr !== 12'h000) begin
      n_fail++; $display("[TB] FAIL clip_h42: got %h expected 000", rom_addr);
    end
    apply_stimulus(11'd2026, 11'd70, 12'h333);
    tick();
    n_checks++;
    if (rom_addr !== 12'h000) begin
      n_fail++; $display("[TB] FAIL clip_h2026: got %h expected 000", rom_addr);
    end
    apply_stimulus(11'd2047, 11'd70, 12'h333);
    tick();
    n_checks++;
    if (rom_addr !== 12'h000) begin
      n_fail++; $display("[TB] FAIL clip_h2047: got %h expected 000", rom_addr);
    end
    repeat (2) tick();
    n_checks++;
    if (rgb_out !== 12'h333) begin
      n_fail++; $display("[TB] FAIL clip_wrap_rgb: got %h expected 333", rgb_out);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    hsync_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
    xpos = '0; ypos = '0;
    apply_stimulus(11'd0, 11'd0, 12'h000);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_latency();
    test_addressing();
    test_frame_latch();
    test_left_clip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
